// File: rtl/preproc_packetizer.sv
// preproc_packetizer: packs pairs of signed ADC samples into 32-bit words,
// groups them into fixed-length packets and streams them out over AXI-Stream
// through a small FIFO. The source cannot be stalled, so a completed word that
// finds the FIFO full is dropped and flagged in the sticky overflow bit.
// Optional: define PREPROC_PKT_HEADER_EN to prefix each packet with a header
// word {16'hA5A5, pkt_count}.
module preproc_packetizer #(
  parameter int ADC_WIDTH  = 14,
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  input  logic [ADC_WIDTH-1:0]  s_data,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  overflow,
  input  logic                  clr_ovf,
  output logic [15:0]           pkt_count
);
  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]    LAST_IDX = 16'(PKT_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic            phase_q, phase_d;        // 1: holding first half of a pair
  logic [15:0]     half_q, half_d;
  logic            stg_vld_q, stg_vld_d;    // completed word waiting for its write slot
  logic [31:0]     stg_data_q, stg_data_d;
  logic [15:0]     word_cnt_q, word_cnt_d;  // payload index of the next successful write
  logic            ovf_q, ovf_d;
  logic [15:0]     pkt_cnt_q, pkt_cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [32:0]     fifo_mem [FIFO_DEPTH];   // {last, data}

  logic [15:0]     sext;
  logic            full, empty, rd_en, is_last, in_pkt, capture;
  logic            wr_req, wr_ok, drop, pay_ok, last_wr;
  logic [32:0]     wr_word;

  assign sext    = {{(16-ADC_WIDTH){s_data[ADC_WIDTH-1]}}, s_data};
  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign rd_en   = !empty && m_tready;
  assign is_last = (word_cnt_q == LAST_IDX);
  // Anything of the current packet already captured but not yet written out.
  assign in_pkt  = (word_cnt_q != '0) || phase_q || stg_vld_q;

`ifdef PREPROC_PKT_HEADER_EN
  logic hdr_done_q, hdr_done_d, hdr_req;
  // The header goes out the cycle after the packet's first sample; a staged
  // payload word can never coincide with that cycle.
  assign hdr_req = phase_q && (word_cnt_q == '0) && !hdr_done_q;
`endif

  // Select the word offered to the FIFO this cycle.
  always_comb begin
    wr_req  = stg_vld_q;
    wr_word = {is_last, stg_data_q};
`ifdef PREPROC_PKT_HEADER_EN
    if (hdr_req) begin
      wr_req  = 1'b1;
      wr_word = {1'b0, 16'hA5A5, pkt_cnt_q};
    end
`endif
  end

  // A same-cycle read frees the slot, so full-with-read still accepts.
  assign wr_ok   = wr_req && (!full || rd_en);
  assign drop    = wr_req && !wr_ok;
  assign pay_ok  = stg_vld_q && wr_ok;
  assign last_wr = pay_ok && is_last;

  // Next-state for FSM, pair packing, counters, flags and FIFO pointers.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    half_d     = half_q;
    stg_vld_d  = 1'b0;
    stg_data_d = stg_data_q;
    word_cnt_d = word_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    ovf_d      = clr_ovf ? 1'b0 : (ovf_q | drop);

    unique case (state_q)
      IDLE: if (enable) state_d = RUN;
      default: begin
        // Stopping goes idle as soon as the packet in flight is complete.
        if (enable)                  state_d = RUN;
        else if (last_wr || !in_pkt) state_d = IDLE;
        else                         state_d = DRAIN;
      end
    endcase

    capture = s_valid && (state_d != IDLE);
    if (capture) begin
      if (!phase_q) begin
        half_d  = sext;
        phase_d = 1'b1;
      end else begin
        stg_vld_d  = 1'b1;
        stg_data_d = {sext, half_q};
        phase_d    = 1'b0;
      end
    end
    if (state_d == IDLE) phase_d = 1'b0;

    if (pay_ok)  word_cnt_d = is_last ? '0 : word_cnt_q + 16'd1;
    if (last_wr) pkt_cnt_d  = pkt_cnt_q + 16'd1;

    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      half_q     <= '0;
      stg_vld_q  <= 1'b0;
      stg_data_q <= '0;
      word_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      half_q     <= half_d;
      stg_vld_q  <= stg_vld_d;
      stg_data_q <= stg_data_d;
      word_cnt_q <= word_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef PREPROC_PKT_HEADER_EN
  // Header is emitted once per packet; re-armed when the packet closes.
  always_comb begin
    hdr_done_d = hdr_done_q;
    if (hdr_req) hdr_done_d = 1'b1;
    if (last_wr || state_d == IDLE) hdr_done_d = 1'b0;
  end

  // Header-issued flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hdr_done_q <= 1'b0;
    else        hdr_done_q <= hdr_done_d;
  end
`endif

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) fifo_mem[wr_ptr_q] <= wr_word;
  end

  assign m_tvalid  = !empty;
  assign m_tdata   = empty ? '0 : fifo_mem[rd_ptr_q][31:0];
  assign m_tlast   = !empty && fifo_mem[rd_ptr_q][32];
  assign overflow  = ovf_q;
  assign pkt_count = pkt_cnt_q;

endmodule
